// File: rtl/button_press_classifier.sv
// Push-button conditioner: 2-FF synchroniser, press/release debounce, and
// short/long classification with optional auto-repeat of the long pulse.
module button_press_classifier #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic inc_short,
    output logic inc_long,
    output logic held
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG_HOLD,
        DEB_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             short_pending_q, short_pending_d;
    logic             held_q, held_d;
    logic             inc_short_q, inc_short_d;
    logic             inc_long_q, inc_long_d;
    logic             btn_s;

    assign btn_s  = sync_q[1];
    assign sync_d = {sync_q[0], btn_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q          <= '0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            rcnt_q          <= '0;
            short_pending_q <= 1'b0;
            held_q          <= 1'b0;
            inc_short_q     <= 1'b0;
            inc_long_q      <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rcnt_q          <= rcnt_d;
            short_pending_q <= short_pending_d;
            held_q          <= held_d;
            inc_short_q     <= inc_short_d;
            inc_long_q      <= inc_long_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rcnt_d          = rcnt_q;
        short_pending_d = short_pending_q;
        held_d          = held_q;
        inc_short_d     = 1'b0;
        inc_long_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end

            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Release is tested first so it wins over the long threshold.
            PRESSED: begin
                if (!btn_s) begin
                    state_d         = DEB_RELEASE;
                    short_pending_d = 1'b1;
                    rcnt_d          = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d    = LONG_HOLD;
                    inc_long_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LONG_HOLD: begin
                if (!btn_s) begin
                    state_d         = DEB_RELEASE;
                    short_pending_d = 1'b0;
                    rcnt_d          = '0;
                end else if (cnt_q == REP_LAST) begin
                    if (REPEAT_EN) begin
                        inc_long_d = 1'b1;
                        cnt_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // cnt is left untouched here so a bounce resumes the hold timing.
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_d = short_pending_q ? PRESSED : LONG_HOLD;
                end else if (rcnt_q == DEB_LAST) begin
                    inc_short_d     = short_pending_q;
                    held_d          = 1'b0;
                    short_pending_d = 1'b0;
                    state_d         = IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inc_short = inc_short_q;
    assign inc_long  = inc_long_q;
    assign held      = held_q;

endmodule
